wb_arbiter: RTL and testbench



---
 rtl/rv_pkg.sv | 17 +
 rtl/wb_arbiter_if.sv | 35 +++
 rtl/wb_fifo.sv | 57 +++++
 rtl/wb_arbiter.sv | 130 +++++++++++++
 tb/tb_wb_arbiter.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared register-file writeback types.
//   REG_ADDR_W / XLEN : register address and data widths
//   wb_req_t          : one register write {rd, data}
//   REG_ZERO          : x0, writes to it are suppressed
package rv_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU result, LSU valid/ready result, register-file
// write port and status.
//   slave  : arbiter side (consumes ALU/LSU, drives write port)
//   master : pipeline / bench side
interface wb_arbiter_if #(
  parameter int unsigned DEPTH = 2
);
  import rv_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [REG_ADDR_W-1:0] lsu_rd;
  logic [XLEN-1:0]       lsu_data;
  logic                  alu_stall;
  logic                  RegWrite;
  logic [REG_ADDR_W-1:0] Rd;
  logic [XLEN-1:0]       Write_data;
  logic [CNT_W-1:0]      fifo_count;

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output lsu_ready, alu_stall, RegWrite, Rd, Write_data, fifo_count
  );

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready, alu_stall, RegWrite, Rd, Write_data, fifo_count
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of register writes for buffered LSU results.
//   clk, reset          : clock, synchronous active-high reset
//   push, push_data     : enqueue (caller must not push when full)
//   pop, pop_data       : dequeue; pop_data shows the head (caller must not pop when empty)
//   full, empty, count  : occupancy status
module wb_fifo
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  wb_req_t                    push_data,
  input  logic                       pop,
  output wb_req_t                    pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  wb_req_t          mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count_q;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy tracking makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter for the single integer register-file write port.
// ALU results win with fixed priority; LSU results are buffered in wb_fifo
// and drained when the ALU is idle. A starvation counter raises alu_stall
// when the FIFO head has lost STARVE_LIMIT consecutive cycles.
//   clk, reset : clock, synchronous active-high reset
//   bus        : wb_arbiter_if.slave (ALU in, LSU valid/ready in, write port out)
// Optional: WB_ARBITER_BYPASS_EN lets an LSU result go straight to the output
// register when the FIFO is empty and the ALU is idle.
module wb_arbiter
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  wb_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT) + 1;
  localparam logic [STV_W-1:0] STV_LAST = STV_W'(STARVE_LIMIT - 1);

  wb_req_t          alu_req;
  wb_req_t          lsu_req;
  wb_req_t          head;
  wb_req_t          win;
  logic             win_valid;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] fifo_count;
  logic             lsu_ready_c;
  logic             accept;
  logic             bypass;
  logic             push;
  logic             pop;
  logic             starve_inc;

  logic                  reg_write_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       data_q;
  logic                  stall_q;
  logic [STV_W-1:0]      starve_cnt;

  // Ready depends only on registered occupancy, never on lsu_valid.
  assign lsu_ready_c = !reset && !full;

  // Accept, push/pop and winner selection.
  always_comb begin
    alu_req    = '{rd: bus.alu_rd, data: bus.alu_data};
    lsu_req    = '{rd: bus.lsu_rd, data: bus.lsu_data};
    accept     = bus.lsu_valid && lsu_ready_c;
`ifdef WB_ARBITER_BYPASS_EN
    bypass     = accept && empty && !bus.alu_valid && (bus.lsu_rd != REG_ZERO);
`else
    bypass     = 1'b0;
`endif
    push       = accept && (bus.lsu_rd != REG_ZERO) && !bypass;
    pop        = !bus.alu_valid && !empty;
    starve_inc = bus.alu_valid && !empty;
    win_valid  = 1'b0;
    win        = alu_req;
    if (bus.alu_valid) begin
      win_valid = 1'b1;
      win       = alu_req;
    end else if (!empty) begin
      win_valid = 1'b1;
      win       = head;
    end else if (bypass) begin
      win_valid = 1'b1;
      win       = lsu_req;
    end
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (lsu_req),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  // Registered write port; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
    end else begin
      reg_write_q <= win_valid && (win.rd != REG_ZERO);
      if (win_valid) begin
        rd_q   <= win.rd;
        data_q <= win.data;
      end
    end
  end

  // Starvation tracking; counter saturates, stall holds until the next pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      if (pop || empty) begin
        starve_cnt <= '0;
      end else if (starve_inc && (starve_cnt != STV_LAST)) begin
        starve_cnt <= starve_cnt + STV_W'(1);
      end
      if (pop) begin
        stall_q <= 1'b0;
      end else if (starve_inc && (starve_cnt == STV_LAST)) begin
        stall_q <= 1'b1;
      end
    end
  end

  assign bus.lsu_ready  = lsu_ready_c;
  assign bus.alu_stall  = stall_q;
  assign bus.RegWrite   = reg_write_q;
  assign bus.Rd         = rd_q;
  assign bus.Write_data = data_q;
  assign bus.fifo_count = fifo_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios followed by random traffic,
// compared every cycle against a queue-based reference model.
module tb_wb_arbiter;
  import rv_pkg::*;

  localparam int unsigned DEPTH        = 2;
  localparam int unsigned STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

  wb_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model state
  wb_req_t     q[$];
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  int          lost;      // cycles the FIFO head has lost since the last pop

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply the arbiter's rules to the model for one clock edge.
  task automatic model_edge(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                            input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                            input bit rst);
    bit      accept, byp, popped, was_empty, have;
    wb_req_t w;
    if (rst) begin
      q.delete();
      m_we   = 1'b0;
      m_rd   = '0;
      m_data = '0;
      lost   = 0;
      return;
    end
    accept    = lv && (q.size() < DEPTH);
    was_empty = (q.size() == 0);
`ifdef WB_ARBITER_BYPASS_EN
    byp = accept && was_empty && !av && (lrd != 5'd0);
`else
    byp = 1'b0;
`endif
    popped = 1'b0;
    have   = 1'b1;
    if (av) begin
      w = '{rd: ard, data: ad};
    end else if (!was_empty) begin
      w      = q.pop_front();
      popped = 1'b1;
    end else if (byp) begin
      w = '{rd: lrd, data: ld};
    end else begin
      have = 1'b0;
      w    = '0;
    end
    if (popped || was_empty) lost = 0;
    else if (av)             lost = lost + 1;
    if (accept && lrd != 5'd0 && !byp) q.push_back('{rd: lrd, data: ld});
    m_we = have && (w.rd != 5'd0);
    if (have) begin
      m_rd   = w.rd;
      m_data = w.data;
    end
  endtask

  // One cycle: drive at negedge, check ready, advance model at posedge, check outputs.
  task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input bit rst);
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.lsu_valid = lv;
    bus.lsu_rd    = lrd;
    bus.lsu_data  = ld;
    reset         = rst;
    #1;
    check("lsu_ready", 32'(bus.lsu_ready), 32'(!rst && (q.size() < DEPTH)));
    @(posedge clk);
    model_edge(av, ard, ad, lv, lrd, ld, rst);
    @(negedge clk);
    check("RegWrite",   32'(bus.RegWrite),   32'(m_we));
    check("Rd",         32'(bus.Rd),         32'(m_rd));
    check("Write_data", bus.Write_data,      m_data);
    check("alu_stall",  32'(bus.alu_stall),  32'(lost >= int'(STARVE_LIMIT)));
    check("fifo_count", 32'(bus.fifo_count), 32'(q.size()));
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  initial begin
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.lsu_valid = 1'b0;
    bus.lsu_rd    = '0;
    bus.lsu_data  = '0;
    reset         = 1'b1;
    @(negedge clk);

    // Reset state
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);

    // ALU write, then idle
    step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0);
    check("alu_write_we", 32'(bus.RegWrite), 32'd1);
    idle();
    check("alu_idle_we", 32'(bus.RegWrite), 32'd0);

    // x0 suppression for ALU and LSU
    step(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 1'b0);
    check("x0_lsu_count", 32'(bus.fifo_count), 32'd0);
    idle();

    // LSU ordering and fill while ALU busy
    step(1'b1, 5'd3, 32'h30, 1'b1, 5'd1, 32'hA, 1'b0);
    step(1'b1, 5'd4, 32'h40, 1'b1, 5'd2, 32'hB, 1'b0);
    check("fill_count", 32'(bus.fifo_count), 32'd2);
    step(1'b1, 5'd6, 32'h60, 1'b1, 5'd9, 32'h99, 1'b0);
    idle();
    check("drain1_rd", 32'(bus.Rd), 32'd1);
    idle();
    check("drain2_rd", 32'(bus.Rd), 32'd2);
    idle();

    // Starvation: one entry, ALU continuously busy
    step(1'b1, 5'd8, 32'h80, 1'b1, 5'd10, 32'hC, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 5'(11 + i), 32'(i), 1'b0, 5'd0, 32'd0, 1'b0);
    check("starve_stall", 32'(bus.alu_stall), 32'd1);
    idle();
    check("starve_lsu_rd", 32'(bus.Rd), 32'd10);
    check("starve_release", 32'(bus.alu_stall), 32'd0);
    idle();

    // Reset mid-operation with two buffered entries
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h20, 1'b0);
    step(1'b1, 5'd2, 32'h2, 1'b1, 5'd21, 32'h21, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd22, 32'h22, 1'b1);
    check("midreset_count", 32'(bus.fifo_count), 32'd0);
    idle();
    check("midreset_nowrite", 32'(bus.RegWrite), 32'd0);
    idle();

    // LSU into an empty FIFO with the ALU idle (bypass latency difference)
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h55, 1'b0);
`ifdef WB_ARBITER_BYPASS_EN
    check("lsu_lat_we", 32'(bus.RegWrite), 32'd1);
`else
    check("lsu_lat_we", 32'(bus.RegWrite), 32'd0);
`endif
    idle();
    check("lsu_lat_rd", 32'(bus.Rd), 32'd7);
    idle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 5'($urandom_range(0, 7)), $urandom(),
           1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom(),
           1'($urandom_range(0, 99) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
